// File: rtl/cape_pkg.sv
// Shared types and mask helpers for the cape_stream SC bit-stream generator.
// Masks are computed at MAX_W bits; callers keep the low WIDTH bits.
package cape_pkg;

  localparam int MAX_W = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Keeps bits width-1..width-p; p falls back to width when prec is 0 or too large.
  function automatic logic [MAX_W-1:0] prec_mask(input int prec, input int width);
    int p;
    logic [MAX_W-1:0] m;
    p = (prec == 0 || prec > width) ? width : prec;
    m = '0;
    for (int k = 0; k < MAX_W; k++) begin
      if (k < width && k >= width - p) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Trailing-zero run of x within width bits; all ones when x is zero.
  function automatic logic [MAX_W-1:0] tz_mask(input logic [MAX_W-1:0] x, input int width);
    logic run;
    logic [MAX_W-1:0] m;
    m = '0;
    run = 1'b1;
    for (int k = 0; k < MAX_W; k++) begin
      if (k < width) begin
        if (x[k]) run = 1'b0;
        if (run) m[k] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/cape_stream_skip_ctr.sv
// Bypass-aware interleaved counter: bypassed bits read as ones for carry
// propagation but are always stored as zero.
module cape_skip_ctr #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] bp,
  output logic [N-1:0] cnt,
  output logic         last
);

  logic [N-1:0] filled;
  logic [N-1:0] cnt_inc;

  assign filled  = cnt | bp;
  assign cnt_inc = (filled + N'(1)) & ~bp;
  assign last    = &filled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/cape_stream.sv
// Handshaked correlated SC bit-stream generator: latches operands on start and
// emits one NUM_INPUTS-wide bit-vector per accepted beat, optionally early-terminating.
module cape_stream
  import cape_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 8,
  localparam int CW        = WIDTH * NUM_INPUTS,
  localparam int PW        = $clog2(WIDTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [NUM_INPUTS-1:0][WIDTH-1:0]      bxs,
  input  logic [PW-1:0]                         prec,
  input  logic                                  et_en,
  output logic                                  busy,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_INPUTS-1:0]                 xs,
  output logic                                  last,
  output logic                                  done,
  output logic [CW:0]                           len
);

  state_t state, state_nxt;

  logic [NUM_INPUTS-1:0][WIDTH-1:0] bxm;
  logic                             et_q;
  logic [CW-1:0]                    bp;
  logic [CW-1:0]                    cnt;
  logic                             ctr_last;
  logic [MAX_W-1:0]                 pmask;
  logic [MAX_W-1:0]                 tzm;
  logic [WIDTH-1:0]                 val;
  logic                             run;
  logic                             accept;
  logic                             beat;

  assign run    = (state == S_RUN);
  assign accept = (state == S_IDLE) && start;
  // abort wins over a simultaneous beat, so it never advances the stream
  assign beat   = run && out_ready && !abort;
  assign pmask  = prec_mask(int'(prec), WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (abort || (out_ready && ctr_last)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    if (state == S_RUN) begin
      busy      = 1'b1;
      out_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bxm  <= '0;
      et_q <= 1'b0;
      len  <= '0;
      done <= 1'b0;
    end else begin
      done <= beat && ctr_last;
      if (accept) begin
        for (int i = 0; i < NUM_INPUTS; i++) bxm[i] <= bxs[i] & pmask[WIDTH-1:0];
        et_q <= et_en;
        len  <= '0;
      end else if (beat) begin
        len <= len + (CW+1)'(1);
      end
    end
  end

  always_comb begin
    bp  = '0;
    tzm = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      tzm = tz_mask(MAX_W'(bxm[i]), WIDTH);
      for (int j = 0; j < WIDTH; j++) bp[j*NUM_INPUTS+i] = et_q & tzm[j];
    end
  end

  always_comb begin
    xs  = '0;
    val = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      for (int j = 0; j < WIDTH; j++) val[j] = cnt[j*NUM_INPUTS+i];
      xs[i] = run && (val < bxm[i]);
    end
  end

  assign last = run && ctr_last;

  cape_skip_ctr #(.N(CW)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (beat),
    .bp    (bp),
    .cnt   (cnt),
    .last  (ctr_last)
  );

endmodule

// File: tb/tb_cape_stream.sv
// Directed bench for cape_stream at WIDTH=4, NUM_INPUTS=2 with hand-computed
// stream lengths, popcounts and handshake timing.
module tb_cape_stream;

  localparam int W  = 4;
  localparam int NI = 2;
  localparam int CW = W * NI;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NI-1:0][W-1:0] bxs = '0;
  logic [2:0]        prec = 3'd0;
  logic              et_en = 1'b0;
  logic              busy;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NI-1:0]     xs;
  logic              last;
  logic              done;
  logic [CW:0]       len;

  int n_cmp = 0;
  int n_err = 0;

  int beats, ones0, ones1, stall_err;
  bit got_last;

  always #5 clk = ~clk;

  cape_stream #(.WIDTH(W), .NUM_INPUTS(NI)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .bxs       (bxs),
    .prec      (prec),
    .et_en     (et_en),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xs        (xs),
    .last      (last),
    .done      (done),
    .len       (len)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [W-1:0] b0, input logic [W-1:0] b1,
                          input logic [2:0] p, input logic et);
    bxs[0] = b0;
    bxs[1] = b1;
    prec   = p;
    et_en  = et;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Runs until the last beat is accepted or the budget expires; returns at edge+1
  // after the final beat's edge.
  task automatic collect(input int budget, input bit rnd, input bit poke,
                         output int nb, output int o0, output int o1,
                         output int serr, output bit gl);
    logic [NI-1:0] hx;
    logic          hl;
    logic [CW:0]   hn;
    bit            stalled;
    nb = 0; o0 = 0; o1 = 0; serr = 0; gl = 1'b0; stalled = 1'b0;
    hx = '0; hl = 1'b0; hn = '0;
    for (int c = 0; c < budget && !gl; c++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke && (c == 5);
      #1;
      if (stalled && (xs !== hx || last !== hl || len !== hn)) serr++;
      if (out_valid && out_ready) begin
        nb++;
        o0 += int'(xs[0]);
        o1 += int'(xs[1]);
        if (last) gl = 1'b1;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        hx = xs; hl = last; hn = len;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_busy",  busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_xs",    xs, 0);
    check("rst_last",  last, 0);
    check("rst_done",  done, 0);
    check("rst_len",   len, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // abort in IDLE has no effect
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);

    // full-length stream, no early termination
    do_start(4'h8, 4'h4, 3'd4, 1'b0);
    check("s1_busy",  busy, 1);
    check("s1_valid", out_valid, 1);
    check("s1_len0",  len, 0);
    collect(400, 1'b0, 1'b0, beats, ones0, ones1, stall_err, got_last);
    check("s1_beats", beats, 256);
    check("s1_ones0", ones0, 128);
    check("s1_ones1", ones1, 64);
    check("s1_last",  got_last, 1);
    check("s1_done",  done, 1);
    check("s1_busy_off", busy, 0);
    check("s1_len",   len, 256);
    @(posedge clk); #1;
    check("s1_done_pulse", done, 0);
    check("s1_len_hold", len, 256);

    // early termination, same operands
    do_start(4'h8, 4'h4, 3'd4, 1'b1);
    collect(100, 1'b0, 1'b0, beats, ones0, ones1, stall_err, got_last);
    check("s2_beats", beats, 8);
    check("s2_ones0", ones0, 4);
    check("s2_ones1", ones1, 2);
    check("s2_done",  done, 1);
    check("s2_len",   len, 8);

    // new start accepted in the done cycle; precision 2 masks to {8,4}
    do_start(4'hB, 4'h7, 3'd2, 1'b1);
    check("s3_busy", busy, 1);
    collect(100, 1'b0, 1'b0, beats, ones0, ones1, stall_err, got_last);
    check("s3_beats", beats, 8);
    check("s3_ones0", ones0, 4);
    check("s3_ones1", ones1, 2);
    check("s3_len",   len, 8);
    @(posedge clk); #1;

    // all-zero operands: single beat; start during that last beat is ignored
    do_start(4'h0, 4'h0, 3'd0, 1'b1);
    check("s4_xs",   xs, 0);
    check("s4_last", last, 1);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    check("s4_done", done, 1);
    check("s4_busy", busy, 0);
    check("s4_len",  len, 1);
    @(posedge clk); #1;
    check("s4_no_restart", busy, 0);

    // random backpressure with a stray start mid-run
    do_start(4'h8, 4'h4, 3'd4, 1'b1);
    collect(300, 1'b1, 1'b1, beats, ones0, ones1, stall_err, got_last);
    check("s5_beats", beats, 8);
    check("s5_ones0", ones0, 4);
    check("s5_ones1", ones1, 2);
    check("s5_stall", stall_err, 0);
    check("s5_last",  got_last, 1);
    check("s5_done",  done, 1);
    check("s5_len",   len, 8);
    @(posedge clk); #1;

    // abort after three beats, with a beat offered in the abort cycle
    do_start(4'h8, 4'h4, 3'd4, 1'b0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s6_len3_pre", len, 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    out_ready = 1'b0;
    check("s6_busy", busy, 0);
    check("s6_done", done, 0);
    check("s6_len",  len, 3);
    @(posedge clk); #1;
    check("s6_done_late", done, 0);

    // asynchronous reset mid-stream
    do_start(4'h8, 4'h4, 3'd4, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s7_busy",  busy, 0);
    check("s7_valid", out_valid, 0);
    check("s7_xs",    xs, 0);
    check("s7_last",  last, 0);
    check("s7_done",  done, 0);
    check("s7_len",   len, 0);
    out_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cape_stream.md
# cape_stream

Handshaked, runtime-configurable successor to the CAPE correlated bit-stream generator for the stochastic-computing datapath. Latches NUM_INPUTS binary operands on `start`, truncates them to a runtime precision, and emits one NUM_INPUTS-wide SC bit-vector per accepted beat over a valid/ready interface. Optional early termination skips every counter bit whose operand bit lies in a trailing-zero region, shortening the stream. It sits between the operand register file and the SC arithmetic lanes, replacing the free-running generator with a start/busy/done transaction.

## Interface
- WIDTH, 8, operand precision in bits
- NUM_INPUTS, 8, number of operands/streams
- CW (localparam), WIDTH*NUM_INPUTS, interleaved counter width
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request a new stream; honoured only in IDLE
- abort  in  1  terminate the current stream in RUN
- bxs  in  NUM_INPUTS x WIDTH  operands, sampled on start acceptance
- prec  in  $clog2(WIDTH+1)  significant bits kept; 0 or >WIDTH means WIDTH
- et_en  in  1  early-termination enable, sampled on start acceptance
- busy  out  1  high in RUN
- out_valid  out  1  xs is valid
- out_ready  in  1  consumer accepts the beat
- xs  out  NUM_INPUTS  SC bit-vector
- last  out  1  current beat is the final one
- done  out  1  one-cycle pulse after the final beat is accepted
- len  out  CW+1  beats accepted in the current/last stream

## Operation
- States IDLE and RUN. Reset: IDLE; busy, out_valid, last, done, xs, len, counter, and latched operands all 0.
- IDLE, start=1: latch `bxm[i] = bxs[i] & mask(prec)`, where the mask keeps bits WIDTH-1..WIDTH-p and p is the effective precision. Latch et_en, clear the counter and len, then go to RUN.
- Comparison value for input i, bit j = cnt[j*NUM_INPUTS+i]. xs[i] = (value_i < bxm[i]), combinational from cnt and the latched operands.
- Bypass vector: bp[j*NUM_INPUTS+i] = et_en & (bit j lies in the trailing-zero run of bxm[i]). A zero operand counts as all trailing zeros.
- Counter advances only on a beat (out_valid & out_ready). The increment acts on non-bypassed bits only, with carry passing through bypassed bits. Bypassed bits stay 0.
- Stream length is L = 2^(CW - popcount(bp)). L=1 when every bit is bypassed; L=2^CW when et_en=0.
- last = RUN & ((cnt | bp) == all ones).
- A beat with last=1 returns the FSM to IDLE and pulses done on the next cycle.
- len increments on every beat. It holds its value in IDLE until the next start is accepted.
- abort in RUN takes priority over a simultaneous beat. That beat is not counted, no done pulse, return to IDLE.
- start while busy is ignored, including in the cycle of the last beat. abort in IDLE is ignored.
- rst_n asserted mid-stream returns to the reset state immediately.

## Timing
- Start accepted at edge t: busy and out_valid high from cycle t+1.
- With out_ready tied high, L beats take exactly L cycles. done is high in the cycle after the last beat; busy is low in that same cycle; a new start is accepted there at the earliest.
- During a stall (out_valid & !out_ready), xs, last, and len are held stable.
- out_valid does not depend combinationally on out_ready.

## Structure
- cape_pkg holds:
  - the state enum
  - function `prec_mask(prec)` returning a WIDTH-bit mask
  - function `tz_mask(x)` returning the WIDTH-bit trailing-zero run, all ones for x=0
- Sub-module cape_skip_ctr (parameter N=CW) has ports clr, en, bp[N], cnt[N], and last. It implements the bypass-aware increment.
- The top level holds the FSM, operand/et_en latches, interleave wiring, comparators, and the len counter.

## Test plan
All scenarios use WIDTH=4, NUM_INPUTS=2.
- et_en=0, bxs={0x8,0x4}, prec=4, ready=1: 256 beats; popcount x0=128, x1=64; last on beat 256 only; done 1 cycle later; len=256.
- et_en=1, same operands: 8 beats; x0 ones=4, x1 ones=2; done 1 cycle after beat 8; len=8.
- et_en=1, prec=2, bxs={0xB,0x7}: masked to {0x8,0x4}; identical result to the previous case.
- et_en=1, bxs={0,0}: 1 beat with xs=0, last=1, then done; len=1.
- et_en=1, bxs={0x8,0x4}, random out_ready: xs/last stable across stalls; still 8 beats and the same popcounts; start pulsed mid-run is ignored.
- abort after 3 beats: busy low next cycle, no done, len=3; separately, rst_n mid-run clears all outputs immediately.
